fetch_prefetch_queue: RTL and testbench

//  Instruction byte prefetcher directly upstream of the fetch stage. Issues 8-byte aligned reads to

---
 rtl/y86_pkg.sv | 14 +
 rtl/byte_ring_buffer.sv | 81 ++++++++
 rtl/fetch_prefetch_queue.sv | 138 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Constants shared by the Y86-64 fetch, prefetch and writeback blocks.
package y86_pkg;

  localparam int Y86_MAX_INSTR_BYTES = 10;
  localparam int IMEM_WORD_BYTES     = 8;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } y86_stat_e;

endpackage

// File: rtl/byte_ring_buffer.sv
// Circular byte queue of {err,byte} entries: pushes up to one imem word from a start
// offset, pops up to one instruction, and exposes a 10-byte window at the read pointer.
module byte_ring_buffer
  import y86_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               push_en,
  input  logic [8*IMEM_WORD_BYTES-1:0]       push_data,
  input  logic                               push_err,
  input  logic [2:0]                         push_start,
  input  logic                               pop_en,
  input  logic [3:0]                         pop_len,
  output logic [CW-1:0]                      count,
  output logic [8*Y86_MAX_INSTR_BYTES-1:0]   win_bytes,
  output logic [Y86_MAX_INSTR_BYTES-1:0]     win_err,
  output logic                               any_err
);

  logic [8:0]    store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] pop_len_w;

  // A pop longer than the queue only happens on a poisoned short window; clamp it.
  always_comb begin
    pop_len_w = CW'(pop_len);
    push_n    = push_en ? CW'(4'd8 - {1'b0, push_start}) : '0;
    pop_n     = '0;
    if (pop_en) pop_n = (pop_len_w > count) ? count : pop_len_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      for (int i = 0; i < IMEM_WORD_BYTES; i++) begin
        if (3'(i) >= push_start)
          store[wr_ptr + PW'(i) - PW'(push_start)] <= {push_err, push_data[8*i +: 8]};
      end
    end
  end

  // Only entries below count are meaningful; everything else reads as zero.
  always_comb begin
    win_bytes = '0;
    win_err   = '0;
    any_err   = 1'b0;
    for (int k = 0; k < Y86_MAX_INSTR_BYTES; k++) begin
      if (CW'(k) < count) begin
        win_bytes[8*k +: 8] = store[rd_ptr + PW'(k)][7:0];
        win_err[k]          = store[rd_ptr + PW'(k)][8];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) any_err = any_err | store[rd_ptr + PW'(i)][8];
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction byte prefetcher feeding the Y86-64 fetch stage with a 10-byte window at the PC.
// Optional statistics counters are built when PREFETCH_STATS_EN is defined.
module fetch_prefetch_queue
  import y86_pkg::*;
#(
  parameter int DEPTH_BYTES     = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        req_valid_o,
  output logic [63:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [63:0] resp_data_i,
  input  logic        resp_error_i,
  output logic        instr_valid_o,
  output logic [63:0] instr_pc_o,
  output logic [79:0] instr_bytes_o,
  output logic        imem_error_o,
  input  logic        take_i,
  input  logic [3:0]  take_len_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic [31:0] perf_empty_o,
  output logic [31:0] perf_flush_o
);

  localparam int PW = $clog2(DEPTH_BYTES);
  localparam int CW = PW + 1;

  logic          started;
  logic          err_stop;
  logic [63:0]   fetch_addr;
  logic [63:0]   pc;
  logic [1:0]    in_flight;
  logic [1:0]    drop;
  logic [2:0]    first_off;
  logic [CW-1:0] count;
  logic [9:0]    win_err;
  logic          any_err;
  logic          slot_ok;
  logic          space_ok;
  logic          hs;
  logic          resp_dec;
  logic          resp_keep;
  logic          take_ok;

  // Request channel: a transfer happens in any cycle with req_valid_o & req_ready_i.
  // Space for every in-flight word is reserved up front, so the queue cannot overflow.
  always_comb begin
    slot_ok       = int'(in_flight) < MAX_OUTSTANDING;
    space_ok      = (DEPTH_BYTES - int'(count)) >= IMEM_WORD_BYTES * (int'(in_flight) + 1);
    req_valid_o   = started & ~err_stop & ~redirect_i & slot_ok & space_ok;
    hs            = req_valid_o & req_ready_i;
    resp_dec      = resp_valid_i & (in_flight != 2'd0);
    resp_keep     = resp_dec & (drop == 2'd0) & ~redirect_i;
    instr_valid_o = (count >= CW'(Y86_MAX_INSTR_BYTES)) | any_err;
    imem_error_o  = |win_err;
    take_ok       = take_i & instr_valid_o & ~redirect_i;
  end

  assign req_addr_o = fetch_addr;
  assign instr_pc_o = pc;

  byte_ring_buffer #(.DEPTH(DEPTH_BYTES)) u_ring (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (redirect_i),
    .push_en    (resp_keep),
    .push_data  (resp_data_i),
    .push_err   (resp_error_i),
    .push_start (first_off),
    .pop_en     (take_ok),
    .pop_len    (take_len_i),
    .count      (count),
    .win_bytes  (instr_bytes_o),
    .win_err    (win_err),
    .any_err    (any_err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started    <= 1'b0;
      err_stop   <= 1'b0;
      fetch_addr <= '0;
      pc         <= '0;
      in_flight  <= '0;
      drop       <= '0;
      first_off  <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_i) begin
        // Everything still outstanding belongs to the old stream and must be discarded.
        pc         <= redirect_pc_i;
        fetch_addr <= {redirect_pc_i[63:3], 3'b000};
        err_stop   <= 1'b0;
        first_off  <= redirect_pc_i[2:0];
        in_flight  <= in_flight - 2'(resp_dec);
        drop       <= in_flight - 2'(resp_dec);
      end else begin
        if (hs) fetch_addr <= fetch_addr + 64'(IMEM_WORD_BYTES);
        in_flight <= in_flight + 2'(hs) - 2'(resp_dec);
        if (resp_dec) begin
          if (drop != 2'd0) begin
            drop <= drop - 2'd1;
          end else begin
            first_off <= 3'd0;
            if (resp_error_i) err_stop <= 1'b1;
          end
        end
        if (take_ok) pc <= pc + 64'(take_len_i);
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] perf_empty_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_empty_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!instr_valid_o && perf_empty_q != '1) perf_empty_q <= perf_empty_q + 32'd1;
      if (redirect_i && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_empty_o = perf_empty_q;
  assign perf_flush_o = perf_flush_q;
`else
  assign perf_empty_o = '0;
  assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed and randomized bench for fetch_prefetch_queue against a byte-queue reference model.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 32;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rst_i;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i;
  logic        resp_valid_i;
  logic [63:0] resp_data_i;
  logic        resp_error_i;
  logic        instr_valid_o;
  logic [63:0] instr_pc_o;
  logic [79:0] instr_bytes_o;
  logic        imem_error_o;
  logic        take_i;
  logic [3:0]  take_len_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic [31:0] perf_empty_o;
  logic [31:0] perf_flush_o;

  fetch_prefetch_queue #(.DEPTH_BYTES(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_error_i(resp_error_i),
    .instr_valid_o(instr_valid_o), .instr_pc_o(instr_pc_o), .instr_bytes_o(instr_bytes_o),
    .imem_error_o(imem_error_o), .take_i(take_i), .take_len_i(take_len_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .perf_empty_o(perf_empty_o), .perf_flush_o(perf_flush_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // reference model: the queue of {err,byte} in PC order plus stream bookkeeping
  logic [8:0]  mq[$];
  logic [63:0] m_pc, m_fa;
  int          m_if, m_drop;
  bit          m_err_stop, m_started;
  logic [2:0]  m_off;
  int          m_empty, m_flush;
  bit          e_valid, e_req_valid;

  // memory side
  logic [63:0] pend_addr[$];
  int          pend_cyc[$];
  logic [63:0] hs_log[$];
  int          cyc = 0;
  int          lat = 1;
  int          resp_pct = 100;
  int          ready_pct = 100;
  bit          err_en = 0;
  logic [63:0] err_word = '0;
  bit          dut_hs;
  logic [63:0] hs_addr;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    logic [7:0] v;
    v = a[7:0] * 8'd13;
    return v ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = mem_byte(a + 64'(b));
    return w;
  endfunction

  function automatic logic [79:0] mem_window(input logic [63:0] a);
    logic [79:0] w;
    for (int k = 0; k < 10; k++) w[8*k +: 8] = mem_byte(a + 64'(k));
    return w;
  endfunction

  function automatic bit model_valid();
    bit v;
    v = (mq.size() >= 10);
    foreach (mq[i]) if (mq[i][8]) v = 1'b1;
    return v;
  endfunction

  function automatic bit pend_ready();
    return (pend_addr.size() > 0) && ((cyc - pend_cyc[0]) >= lat);
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_outputs();
    int          n;
    logic [79:0] eb;
    logic        eerr;
    n    = mq.size();
    eb   = '0;
    eerr = 1'b0;
    e_valid = model_valid();
    for (int k = 0; k < 10 && k < n; k++) begin
      eb[8*k +: 8] = mq[k][7:0];
      eerr = eerr | mq[k][8];
    end
    e_req_valid = m_started && !m_err_stop && !redirect_i && (m_if < MAXO) &&
                  ((DEPTH - n) >= 8 * (m_if + 1));
    chk("req_valid", 80'(req_valid_o), 80'(e_req_valid));
    chk("req_addr", 80'(req_addr_o), 80'(m_fa));
    chk("instr_valid", 80'(instr_valid_o), 80'(e_valid));
    chk("instr_pc", 80'(instr_pc_o), 80'(m_pc));
    chk("instr_bytes", instr_bytes_o, eb);
    chk("imem_error", 80'(imem_error_o), 80'(eerr));
`ifdef PREFETCH_STATS_EN
    chk("perf_empty", 80'(perf_empty_o), 80'(m_empty));
    chk("perf_flush", 80'(perf_flush_o), 80'(m_flush));
`else
    chk("perf_empty", 80'(perf_empty_o), 80'(0));
    chk("perf_flush", 80'(perf_flush_o), 80'(0));
`endif
  endtask

  task automatic model_step();
    bit rv;
    int n;
    rv = resp_valid_i && (m_if > 0);
    if (!e_valid) m_empty++;
    if (redirect_i) begin
      m_flush++;
      mq.delete();
      m_pc       = redirect_pc_i;
      m_fa       = {redirect_pc_i[63:3], 3'b000};
      m_err_stop = 1'b0;
      m_off      = redirect_pc_i[2:0];
      if (rv) m_if--;
      m_drop = m_if;
    end else begin
      if (take_i && e_valid) begin
        n = (int'(take_len_i) < mq.size()) ? int'(take_len_i) : mq.size();
        repeat (n) void'(mq.pop_front());
        m_pc = m_pc + 64'(take_len_i);
      end
      if (rv) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          for (int b = int'(m_off); b < 8; b++) mq.push_back({resp_error_i, resp_data_i[8*b +: 8]});
          if (resp_error_i) m_err_stop = 1'b1;
          m_off = 3'd0;
        end
        m_if--;
      end
      if (e_req_valid && req_ready_i) begin
        m_fa = m_fa + 64'd8;
        m_if++;
      end
    end
    m_started = 1'b1;
    if (resp_valid_i) begin
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    if (dut_hs) begin
      pend_addr.push_back(hs_addr);
      pend_cyc.push_back(cyc);
      hs_log.push_back(hs_addr);
    end
    cyc++;
  endtask

  // driver: one clock cycle of stimulus, checked before the edge and modelled at it
  task automatic cycle(input bit tk, input int ln, input bit rd, input logic [63:0] rpc);
    @(negedge clk);
    req_ready_i = (int'($urandom_range(99)) < ready_pct);
    if (pend_ready() && int'($urandom_range(99)) < resp_pct) begin
      resp_valid_i = 1'b1;
      resp_data_i  = mem_word(pend_addr[0]);
      resp_error_i = err_en && (pend_addr[0] == err_word);
    end else begin
      resp_valid_i = 1'b0;
      resp_data_i  = '0;
      resp_error_i = 1'b0;
    end
    take_i        = tk;
    take_len_i    = 4'(ln);
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
    expect_outputs();
    dut_hs  = req_valid_o && req_ready_i;
    hs_addr = req_addr_o;
    @(posedge clk);
    model_step();
    #1;
    resp_valid_i = 1'b0;
    resp_error_i = 1'b0;
    resp_data_i  = '0;
    take_i       = 1'b0;
    redirect_i   = 1'b0;
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_i        = 1'b1;
    resp_valid_i = 1'b0;
    resp_error_i = 1'b0;
    take_i       = 1'b0;
    redirect_i   = 1'b0;
    mq.delete();
    pend_addr.delete();
    pend_cyc.delete();
    m_pc = '0; m_fa = '0; m_if = 0; m_drop = 0;
    m_err_stop = 1'b0; m_started = 1'b0; m_off = 3'd0;
    m_empty = 0; m_flush = 0;
    #1;
    expect_outputs();
    repeat (n) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  int lens[4] = '{10, 2, 9, 1};
  logic [63:0] pcs[5] = '{64'h0, 64'hA, 64'hC, 64'h15, 64'h16};
  bit found;
  bit rd;
  logic [63:0] rpc;

  initial begin
    rst_i = 1'b1; req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;
    resp_error_i = 1'b0; take_i = 1'b0; take_len_i = 4'd1; redirect_i = 1'b0;
    redirect_pc_i = '0;

    // 1: fill from PC 0 with single-cycle memory
    do_reset(2);
    hs_log.delete();
    repeat (40) cycle(0, 1, 0, '0);
    while (hs_log.size() < 4) hs_log.push_back('1);
    chk("t1_addr0", 80'(hs_log[0]), 80'(64'h0));
    chk("t1_addr1", 80'(hs_log[1]), 80'(64'h8));
    chk("t1_addr2", 80'(hs_log[2]), 80'(64'h10));
    chk("t1_addr3", 80'(hs_log[3]), 80'(64'h18));
    chk("t1_stop", 80'(req_valid_o), 80'(1'b0));
    chk("t1_valid", 80'(instr_valid_o), 80'(1'b1));

    // 2: variable-length takes
    for (int i = 0; i < 4; i++) begin
      chk("t2_pc", 80'(instr_pc_o), 80'(pcs[i]));
      chk("t2_bytes", instr_bytes_o, mem_window(pcs[i]));
      cycle(1, lens[i], 0, '0);
    end
    chk("t2_pc_end", 80'(instr_pc_o), 80'(pcs[4]));
    chk("t2_bytes_end", instr_bytes_o, mem_window(pcs[4]));

    // 3: redirect with two requests outstanding
    lat = 3;
    cycle(0, 1, 1, 64'h100);
    for (int i = 0; i < 30 && m_if < 2; i++) cycle(0, 1, 0, '0);
    chk("t3_setup_inflight", 80'(m_if), 80'(2));
    resp_pct = 0;
    cycle(0, 1, 1, 64'h45);
    resp_pct = 100;
    hs_log.delete();
    for (int i = 0; i < 40 && !model_valid(); i++) cycle(0, 1, 0, '0);
    if (hs_log.size() == 0) hs_log.push_back('1);
    chk("t3_first_addr", 80'(hs_log[0]), 80'(64'h40));
    chk("t3_valid", 80'(instr_valid_o), 80'(1'b1));
    chk("t3_pc", 80'(instr_pc_o), 80'(64'h45));
    chk("t3_byte0", 80'(instr_bytes_o[7:0]), 80'(mem_byte(64'h45)));

    // 4: poisoned word inside the window
    lat = 1;
    err_en = 1'b1;
    err_word = 64'h18;
    cycle(0, 1, 1, 64'h12);
    repeat (30) cycle(0, 1, 0, '0);
    chk("t4_valid", 80'(instr_valid_o), 80'(1'b1));
    chk("t4_err", 80'(imem_error_o), 80'(1'b1));
    chk("t4_no_req", 80'(req_valid_o), 80'(1'b0));
    cycle(0, 1, 1, 64'h0);
    err_en = 1'b0;
    chk("t4_err_clear", 80'(imem_error_o), 80'(1'b0));
    chk("t4_restart", 80'(req_valid_o), 80'(1'b1));

    // 5: redirect, take and response together; then reset mid-burst
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (model_valid() && pend_ready()) begin
        cycle(1, 3, 1, 64'h333);
        found = 1'b1;
      end else begin
        cycle(1, 2, 0, '0);
      end
    end
    chk("t5_found", 80'(found), 80'(1'b1));
    chk("t5_pc", 80'(instr_pc_o), 80'(64'h333));
    chk("t5_valid", 80'(instr_valid_o), 80'(1'b0));
    repeat (6) cycle(1, 4, 0, '0);
    do_reset(2);
    chk("t5_rst_pc", 80'(instr_pc_o), 80'(0));

    // 6: statistics
    ready_pct = 0;
    repeat (5) cycle(0, 1, 0, '0);
`ifdef PREFETCH_STATS_EN
    chk("t6_empty", 80'(perf_empty_o), 80'(5));
`else
    chk("t6_empty", 80'(perf_empty_o), 80'(0));
`endif
    cycle(0, 1, 1, 64'h80);
    cycle(0, 1, 1, 64'h90);
`ifdef PREFETCH_STATS_EN
    chk("t6_flush", 80'(perf_flush_o), 80'(2));
`else
    chk("t6_flush", 80'(perf_flush_o), 80'(0));
`endif

    // 7: randomized traffic
    ready_pct = 70;
    resp_pct  = 60;
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) lat = int'($urandom_range(4, 1));
      if (i % 250 == 50) begin
        err_en   = 1'b1;
        err_word = {m_fa[63:3] + 61'd2, 3'b000};
      end
      if (i % 250 == 200) err_en = 1'b0;
      rd = ($urandom_range(99) < 3);
      if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      else rpc = {$urandom, $urandom};
      cycle(bit'($urandom_range(1)), int'($urandom_range(10, 1)), rd, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
